// File: rtl/command_decoder_if.sv
// Handshake and FIFO bundle between the command decoder, the command reader's
// FIFO and the clear/triangle/swap engines.
interface command_decoder_if #(
    parameter int unsigned COUNT_WIDTH = 16
);
    logic                   reader_ready;
    logic                   fifo_empty;
    logic [63:0]            fifo_q;
    logic                   fifo_rdreq;
    logic                   clear_valid;
    logic [23:0]            clear_color;
    logic                   clear_ready;
    logic                   tri_valid;
    logic [191:0]           tri_data;
    logic                   tri_ready;
    logic                   swap_req;
    logic                   swap_done;
    logic                   done;
    logic                   error;
    logic [COUNT_WIDTH-1:0] triangles_drawn;

    modport master (
        input  reader_ready, fifo_empty, fifo_q, clear_ready, tri_ready, swap_done,
        output fifo_rdreq, clear_valid, clear_color, tri_valid, tri_data,
               swap_req, done, error, triangles_drawn
    );

    modport slave (
        output reader_ready, fifo_empty, fifo_q, clear_ready, tri_ready, swap_done,
        input  fifo_rdreq, clear_valid, clear_color, tri_valid, tri_data,
               swap_req, done, error, triangles_drawn
    );
endinterface

// File: rtl/command_decoder.sv
// Parses 64-bit command words from the reader FIFO into clear, triangle,
// swap and end-of-list operations for the downstream engines.
module command_decoder #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              restart,
    command_decoder_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, FETCH_VTX, CAPTURE_VTX,
        WAIT_CLEAR, WAIT_TRI, WAIT_SWAP, HALT
    } state_t;

    typedef enum logic [7:0] {
        OP_NOP      = 8'h00,
        OP_CLEAR    = 8'h01,
        OP_TRIANGLE = 8'h02,
        OP_SWAP     = 8'h03,
        OP_END      = 8'h04
    } opcode_t;

    state_t                 state;
    logic [1:0]             vtx;
    logic [63:0]            vert0, vert1, vert2;
    logic [23:0]            clear_color;
    logic                   clear_valid;
    logic                   tri_valid;
    logic                   swap_req;
    logic                   done;
    logic                   error;
    logic [COUNT_WIDTH-1:0] tri_count;
    logic                   pop;

    // The FIFO has no look-ahead, so every pop is followed by a cycle that consumes fifo_q.
    assign pop = (state == FETCH || state == FETCH_VTX) && !bus.fifo_empty
                 && bus.reader_ready && !restart;

    assign bus.fifo_rdreq      = pop;
    assign bus.clear_valid     = clear_valid;
    assign bus.clear_color     = clear_color;
    assign bus.tri_valid       = tri_valid;
    assign bus.tri_data        = {vert2, vert1, vert0};
    assign bus.swap_req        = swap_req;
    assign bus.done            = done;
    assign bus.error           = error;
    assign bus.triangles_drawn = tri_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            vtx         <= '0;
            vert0       <= '0;
            vert1       <= '0;
            vert2       <= '0;
            clear_color <= '0;
            clear_valid <= 1'b0;
            tri_valid   <= 1'b0;
            swap_req    <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            tri_count   <= '0;
        end else if (restart) begin
            // Vertex slots keep stale data; tri_valid low and vtx=0 make them unreachable.
            state       <= IDLE;
            vtx         <= '0;
            clear_valid <= 1'b0;
            tri_valid   <= 1'b0;
            swap_req    <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            tri_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.reader_ready) state <= FETCH;
                end
                FETCH: begin
                    if (pop) state <= DECODE;
                end
                DECODE: begin
                    case (bus.fifo_q[7:0])
                        OP_NOP: state <= FETCH;
                        OP_CLEAR: begin
                            clear_color <= bus.fifo_q[31:8];
                            clear_valid <= 1'b1;
                            state       <= WAIT_CLEAR;
                        end
                        OP_TRIANGLE: begin
                            vtx   <= '0;
                            state <= FETCH_VTX;
                        end
                        OP_SWAP: begin
                            swap_req <= 1'b1;
                            state    <= WAIT_SWAP;
                        end
                        OP_END: begin
                            done  <= 1'b1;
                            state <= HALT;
                        end
                        default: begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= HALT;
                        end
                    endcase
                end
                FETCH_VTX: begin
                    if (pop) state <= CAPTURE_VTX;
                end
                CAPTURE_VTX: begin
                    case (vtx)
                        2'd0:    vert0 <= bus.fifo_q;
                        2'd1:    vert1 <= bus.fifo_q;
                        default: vert2 <= bus.fifo_q;
                    endcase
                    if (vtx == 2'd2) begin
                        tri_valid <= 1'b1;
                        state     <= WAIT_TRI;
                    end else begin
                        vtx   <= vtx + 2'd1;
                        state <= FETCH_VTX;
                    end
                end
                WAIT_CLEAR: begin
                    if (clear_valid && bus.clear_ready) begin
                        clear_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                WAIT_TRI: begin
                    if (tri_valid && bus.tri_ready) begin
                        tri_valid <= 1'b0;
                        tri_count <= tri_count + COUNT_WIDTH'(1);
                        state     <= FETCH;
                    end
                end
                WAIT_SWAP: begin
                    if (bus.swap_done) begin
                        swap_req <= 1'b0;
                        state    <= FETCH;
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
